// File: rtl/expr_sig_pkg.sv
// Shared types and constants for the expression response-capture stage.
package expr_sig_pkg;

  localparam int Y_W   = 90;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  // CRC-32 generator polynomial used as the MISR feedback taps.
  localparam logic [SIG_W-1:0] SIG_POLY = 32'h04C11DB7;
  // Signature value at the start of every run.
  localparam logic [SIG_W-1:0] SIG_SEED = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/expr_misr_step.sv
// One MISR step: fold the wide result vector to signature width, then shift
// the signature with polynomial feedback and mix in the folded word.
module expr_misr_step #(
  parameter int Y_W   = 90,
  parameter int SIG_W = 32
) (
  input  logic [SIG_W-1:0] sig,
  input  logic [Y_W-1:0]   y,
  output logic [SIG_W-1:0] sig_next
);
  import expr_sig_pkg::*;

  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] feedback;

  // Fold the two full words and the zero-extended top slice, then step the MISR.
  always_comb begin
    fold     = y[SIG_W-1:0] ^ y[2*SIG_W-1:SIG_W] ^ SIG_W'(y[Y_W-1:2*SIG_W]);
    feedback = sig[SIG_W-1] ? SIG_POLY : '0;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ feedback ^ fold;
  end

endmodule

// File: rtl/expr_sig_capture.sv
// Response-capture stage: compresses a programmed number of result vectors
// into a MISR signature and compares it with a golden value.
module expr_sig_capture #(
  parameter int Y_W   = 90,
  parameter int SIG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [SIG_W-1:0] golden,
  input  logic             in_valid,
  input  logic [Y_W-1:0]   in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);
  import expr_sig_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;

  logic [SIG_W-1:0] sig_step;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  expr_misr_step #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W)
  ) u_misr_step (
    .sig      (sig_q),
    .y        (in_y),
    .sig_next (sig_step)
  );

  assign accept  = in_valid && (state_q == ST_RUN);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state logic for the FSM, run parameters, signature, count and result.
  always_comb begin
    // NOTE: every target gets a hold default first so no path through the case infers a latch.
    state_d   = state_q;
    num_vec_d = num_vec_q;
    golden_d  = golden_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_vec_d = num_vec;
          golden_d  = golden;
          sig_d     = SIG_SEED;
          cnt_d     = '0;
          pass_d    = 1'b0;
          state_d   = (num_vec == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; a run always completes as programmed.
        if (accept) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (cnt_inc == num_vec_q) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        pass_d  = (sig_q == golden_q);
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset to the idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      num_vec_q <= '0;
      golden_q  <= '0;
      sig_q     <= SIG_SEED;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      golden_q  <= golden_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign in_ready  = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule

// File: tb/tb_expr_sig_capture.sv
// Directed self-checking bench for expr_sig_capture.
module tb_expr_sig_capture;

  localparam int Y_W   = 90;
  localparam int SIG_W = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic [SIG_W-1:0] golden;
  logic             in_valid;
  logic [Y_W-1:0]   in_y;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] vec_count;

  // Standalone step instance, cross-checked against the bench's own model.
  logic [SIG_W-1:0] ref_sig;
  logic [Y_W-1:0]   ref_y;
  logic [SIG_W-1:0] ref_next;

  int n_vec = 0;
  int n_err = 0;

  expr_sig_capture #(.Y_W(Y_W), .SIG_W(SIG_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .golden    (golden),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .signature (signature),
    .vec_count (vec_count)
  );

  expr_misr_step #(.Y_W(Y_W), .SIG_W(SIG_W)) ref_step (
    .sig      (ref_sig),
    .y        (ref_y),
    .sig_next (ref_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the fold and one MISR step.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  function automatic logic [89:0] rand_y();
    return {$urandom_range(0, 32'h03FFFFFF), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] g);
    start   = 1'b1;
    num_vec = n;
    golden  = g;
    tick();
    start   = 1'b0;
    num_vec = $urandom();
    golden  = $urandom();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    if (in_ready !== 1'b0) begin $display("FAIL reset_in_ready: got %b expected 0", in_ready); n_err++; end n_vec++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); n_err++; end n_vec++;
    if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); n_err++; end n_vec++;
    if (pass !== 1'b0) begin $display("FAIL reset_pass: got %b expected 0", pass); n_err++; end n_vec++;
    if (signature !== 32'hFFFFFFFF) begin $display("FAIL reset_sig: got %h expected ffffffff", signature); n_err++; end n_vec++;
    if (vec_count !== 16'd0) begin $display("FAIL reset_count: got %0d expected 0", vec_count); n_err++; end n_vec++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_empty_run();
    pulse_start(16'd0, 32'hFFFFFFFF);
    if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL empty_check_state: got ready=%b busy=%b done=%b expected 0 1 0", in_ready, busy, done); n_err++;
    end n_vec++;
    tick();
    if (in_ready !== 1'b0 || done !== 1'b1 || pass !== 1'b1) begin
      $display("FAIL empty_done: got ready=%b done=%b pass=%b expected 0 1 1", in_ready, done, pass); n_err++;
    end n_vec++;
    if (signature !== 32'hFFFFFFFF) begin $display("FAIL empty_sig: got %h expected ffffffff", signature); n_err++; end n_vec++;
  endtask

  // One zero vector; golden selects the expected pass value.
  task automatic run_single_zero(input logic [SIG_W-1:0] g, input logic exp_pass, input string tag);
    pulse_start(16'd1, g);
    if (in_ready !== 1'b1) begin $display("FAIL %s_ready: got %b expected 1", tag, in_ready); n_err++; end n_vec++;
    in_valid = 1'b1;
    in_y     = '0;
    tick();
    in_valid = 1'b0;
    in_y     = rand_y();
    if (signature !== 32'hFB3EE249) begin $display("FAIL %s_sig: got %h expected fb3ee249", tag, signature); n_err++; end n_vec++;
    if (vec_count !== 16'd1) begin $display("FAIL %s_count: got %0d expected 1", tag, vec_count); n_err++; end n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL %s_check_state: got ready=%b busy=%b done=%b expected 0 1 0", tag, in_ready, busy, done); n_err++;
    end n_vec++;
    tick();
    if (done !== 1'b1 || pass !== exp_pass) begin
      $display("FAIL %s_result: got done=%b pass=%b expected 1 %b", tag, done, pass, exp_pass); n_err++;
    end n_vec++;
  endtask

  task automatic test_single_zero();
    run_single_zero(32'hFB3EE249, 1'b1, "zero");
  endtask

  task automatic test_mismatch();
    run_single_zero(32'h0, 1'b0, "mismatch");
    // DONE must ignore incoming traffic and hold every output.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_y     = rand_y();
      tick();
    end
    in_valid = 1'b0;
    if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL mismatch_hold_flags: got done=%b pass=%b busy=%b ready=%b expected 1 0 0 0", done, pass, busy, in_ready); n_err++;
    end n_vec++;
    if (signature !== 32'hFB3EE249 || vec_count !== 16'd1) begin
      $display("FAIL mismatch_hold_data: got sig=%h cnt=%0d expected fb3ee249 1", signature, vec_count); n_err++;
    end n_vec++;
  endtask

  task automatic test_backpressure();
    logic [6:0]  pattern;
    logic [89:0] ys[4];
    logic [31:0] exp_sig;
    int          acc;
    pattern = 7'b1011001;   // bit i is in_valid on cycle i: 1,0,0,1,1,0,1
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      ys[i]   = rand_y();
      ref_sig = exp_sig;
      ref_y   = ys[i];
      #1;
      if (ref_next !== model_step(exp_sig, ys[i])) begin
        $display("FAIL step_module_%0d: got %h expected %h", i, ref_next, model_step(exp_sig, ys[i])); n_err++;
      end n_vec++;
      exp_sig = model_step(exp_sig, ys[i]);
    end
    pulse_start(16'd4, exp_sig);
    exp_sig = 32'hFFFFFFFF;
    acc     = 0;
    for (int c = 0; c < 7; c++) begin
      in_valid = pattern[c];
      in_y     = pattern[c] ? ys[acc] : rand_y();
      tick();
      if (pattern[c]) begin
        exp_sig = model_step(exp_sig, ys[acc]);
        acc++;
      end
      if (signature !== exp_sig || vec_count !== CNT_W'(acc)) begin
        $display("FAIL bp_cycle_%0d: got sig=%h cnt=%0d expected %h %0d", c, signature, vec_count, exp_sig, acc); n_err++;
      end n_vec++;
    end
    in_valid = 1'b1;
    in_y     = rand_y();
    if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bp_check_state: got ready=%b done=%b busy=%b expected 0 0 1", in_ready, done, busy); n_err++;
    end n_vec++;
    tick();
    in_valid = 1'b0;
    if (done !== 1'b1 || pass !== 1'b1 || signature !== exp_sig || vec_count !== 16'd4) begin
      $display("FAIL bp_done: got done=%b pass=%b sig=%h cnt=%0d expected 1 1 %h 4", done, pass, signature, vec_count, exp_sig); n_err++;
    end n_vec++;
  endtask

  task automatic test_ignored_start();
    logic [89:0] ys[3];
    logic [31:0] exp_sig;
    logic [31:0] sig_after1;
    exp_sig = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      ys[i]   = rand_y();
      exp_sig = model_step(exp_sig, ys[i]);
    end
    sig_after1 = model_step(32'hFFFFFFFF, ys[0]);
    pulse_start(16'd3, exp_sig);
    in_valid = 1'b1;
    in_y     = ys[0];
    tick();
    in_valid = 1'b0;
    // Start with a different programme while in RUN must change nothing.
    pulse_start(16'd1, 32'h0);
    if (signature !== sig_after1 || vec_count !== 16'd1 || in_ready !== 1'b1) begin
      $display("FAIL ignore_hold: got sig=%h cnt=%0d ready=%b expected %h 1 1", signature, vec_count, in_ready, sig_after1); n_err++;
    end n_vec++;
    for (int i = 1; i < 3; i++) begin
      in_valid = 1'b1;
      in_y     = ys[i];
      tick();
    end
    in_valid = 1'b0;
    if (busy !== 1'b1 || done !== 1'b0 || vec_count !== 16'd3) begin
      $display("FAIL ignore_check_state: got busy=%b done=%b cnt=%0d expected 1 0 3", busy, done, vec_count); n_err++;
    end n_vec++;
    tick();
    if (done !== 1'b1 || pass !== 1'b1 || signature !== exp_sig) begin
      $display("FAIL ignore_done: got done=%b pass=%b sig=%h expected 1 1 %h", done, pass, signature, exp_sig); n_err++;
    end n_vec++;
  endtask

  task automatic test_reset_midrun();
    pulse_start(16'd5, 32'h12345678);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_y     = rand_y();
      tick();
    end
    in_valid = 1'b1;
    if (vec_count !== 16'd2) begin $display("FAIL midrun_pre_count: got %0d expected 2", vec_count); n_err++; end n_vec++;
    #2;
    rst_n = 1'b0;
    #1;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      $display("FAIL midrun_reset_flags: got ready=%b busy=%b done=%b pass=%b expected 0 0 0 0", in_ready, busy, done, pass); n_err++;
    end n_vec++;
    if (signature !== 32'hFFFFFFFF || vec_count !== 16'd0) begin
      $display("FAIL midrun_reset_data: got sig=%h cnt=%0d expected ffffffff 0", signature, vec_count); n_err++;
    end n_vec++;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    if (in_ready !== 1'b0 || vec_count !== 16'd0 || signature !== 32'hFFFFFFFF) begin
      $display("FAIL midrun_idle_wait: got ready=%b cnt=%0d sig=%h expected 0 0 ffffffff", in_ready, vec_count, signature); n_err++;
    end n_vec++;
    in_valid = 1'b0;
    run_single_zero(32'hFB3EE249, 1'b1, "restart");
  endtask

  initial begin
    start    = 1'b0;
    num_vec  = '0;
    golden   = '0;
    in_valid = 1'b0;
    in_y     = '0;
    ref_sig  = '0;
    ref_y    = '0;
    test_reset();
    test_empty_run();
    test_single_zero();
    test_mismatch();
    test_backpressure();
    test_ignored_start();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
